// File: rtl/rc_pkg.sv
// Shared reservoir-computing constants, accumulator sizing and readout FSM states.
// Also used by the reservoir and training blocks.
package rc_pkg;

  localparam int N     = 20;
  localparam int XW    = 16;
  localparam int WW    = 8;
  localparam int YW    = 16;
  localparam int SHIFT = 8;

  // Wide enough to hold n full-scale products without wrap.
  function automatic int calc_aw(input int xw, input int ww, input int n);
    return xw + ww + $clog2(n);
  endfunction

  localparam int AW = calc_aw(XW, WW, N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/reservoir_readout_mac_if.sv
// Snapshot/result bundle between the reservoir, the readout MAC and its consumer.
interface reservoir_readout_mac_if #(
  parameter int N  = rc_pkg::N,
  parameter int XW = rc_pkg::XW,
  parameter int WW = rc_pkg::WW,
  parameter int YW = rc_pkg::YW
);

  logic            start;
  logic [N*XW-1:0] x_flat;
  logic [N*WW-1:0] w_flat;
  logic            out_ready;
  logic            busy;
  logic            y_valid;
  logic [YW-1:0]   y_data;
  logic            overflow;
  logic            start_dropped;

  modport master (
    output start, x_flat, w_flat, out_ready,
    input  busy, y_valid, y_data, overflow, start_dropped
  );

  modport slave (
    input  start, x_flat, w_flat, out_ready,
    output busy, y_valid, y_data, overflow, start_dropped
  );

endinterface

// File: rtl/rc_sat_shift.sv
// Truncating right shift of an accumulator followed by unsigned saturation to YW bits.
module rc_sat_shift #(
  parameter int AW    = rc_pkg::AW,
  parameter int YW    = rc_pkg::YW,
  parameter int SHIFT = rc_pkg::SHIFT
) (
  input  logic [AW-1:0] acc_in,
  output logic [YW-1:0] y_out,
  output logic          overflow
);

  logic [AW-1:0] shifted;

  assign shifted  = acc_in >> SHIFT;
  // Any set bit above the result width means the value does not fit.
  assign overflow = |shifted[AW-1:YW];
  assign y_out    = overflow ? {YW{1'b1}} : shifted[YW-1:0];

endmodule

// File: rtl/reservoir_readout_mac.sv
// Readout stage: snapshots N neuron outputs and weights, then sums x_i*w_i with one
// MAC per clock and presents the scaled, saturated result on a valid/ready port.
module reservoir_readout_mac #(
  parameter int N     = rc_pkg::N,
  parameter int XW    = rc_pkg::XW,
  parameter int WW    = rc_pkg::WW,
  parameter int YW    = rc_pkg::YW,
  parameter int SHIFT = rc_pkg::SHIFT
) (
  input  logic                  clk,
  input  logic                  reset,
  reservoir_readout_mac_if.slave bus
);

  import rc_pkg::*;

  localparam int AW = calc_aw(XW, WW, N);
  localparam int IW = $clog2(N);
  localparam int PW = XW + WW;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg;
  logic [AW-1:0]   acc_reg;
  logic [YW-1:0]   y_data_reg;
  logic            overflow_reg;
  logic            start_dropped_reg;

  logic [XW-1:0]   x_snap_reg [N];
  logic [WW-1:0]   w_snap_reg [N];

  logic            capture;
  logic            last_term;
  logic [PW-1:0]   product;
  logic [AW-1:0]   acc_sum;
  logic [YW-1:0]   sat_y;
  logic            sat_ovf;
  logic            busy;
  logic            y_valid;

  assign capture   = (state_reg == IDLE) && bus.start;
  assign last_term = (idx_reg == IW'(N - 1));
  assign product   = PW'(x_snap_reg[idx_reg]) * PW'(w_snap_reg[idx_reg]);
  assign acc_sum   = acc_reg + AW'(product);

  // Inputs are only trusted on the start edge; afterwards the snapshot is the source.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_snap
      always_ff @(posedge clk) begin
        if (reset) begin
          x_snap_reg[gi] <= '0;
          w_snap_reg[gi] <= '0;
        end else if (capture) begin
          x_snap_reg[gi] <= bus.x_flat[gi*XW +: XW];
          w_snap_reg[gi] <= bus.w_flat[gi*WW +: WW];
        end
      end
    end
  endgenerate

  rc_sat_shift #(
    .AW    (AW),
    .YW    (YW),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .acc_in   (acc_sum),
    .y_out    (sat_y),
    .overflow (sat_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      idx_reg           <= '0;
      acc_reg           <= '0;
      y_data_reg        <= '0;
      overflow_reg      <= 1'b0;
      start_dropped_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (bus.start && (state_reg != IDLE)) begin
        start_dropped_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            acc_reg <= '0;
            idx_reg <= '0;
          end
        end
        ACC: begin
          acc_reg <= acc_sum;
          if (last_term) begin
            y_data_reg   <= sat_y;
            overflow_reg <= sat_ovf;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start)     state_next = ACC;
      ACC:     if (last_term)     state_next = OUT;
      OUT:     if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    y_valid = 1'b0;
    case (state_reg)
      ACC: busy = 1'b1;
      OUT: begin
        busy    = 1'b1;
        y_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy          = busy;
  assign bus.y_valid       = y_valid;
  assign bus.y_data        = y_data_reg;
  assign bus.overflow      = overflow_reg;
  assign bus.start_dropped = start_dropped_reg;

endmodule

// File: tb/tb_reservoir_readout_mac.sv
// Directed bench for reservoir_readout_mac: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on every output handshake.
module tb_reservoir_readout_mac;

  import rc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reservoir_readout_mac_if bus ();

  reservoir_readout_mac dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [YW-1:0] y;
    logic          ovf;
    string         name;
  } exp_t;

  exp_t          sb_q[$];
  int            n_compared   = 0;
  int            n_mismatched = 0;
  logic [XW-1:0] xv [N];
  logic [WW-1:0] wv [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drive_vec();
    for (int i = 0; i < N; i++) begin
      bus.x_flat[i*XW +: XW] = xv[i];
      bus.w_flat[i*WW +: WW] = wv[i];
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) begin
      bus.x_flat[i*XW +: XW] = XW'($urandom);
      bus.w_flat[i*WW +: WW] = WW'($urandom);
    end
  endtask

  task automatic set_all(input logic [XW-1:0] x, input logic [WW-1:0] w);
    for (int i = 0; i < N; i++) begin
      xv[i] = x;
      wv[i] = w;
    end
  endtask

  // One transaction: start pulse, bounded wait for y_valid, optional stall, handshake.
  task automatic run_txn(input string name, input logic [YW-1:0] ey, input logic eovf,
                         input int stall, input bit drop);
    exp_t e;
    int   cycles;
    bit   got;
    @(posedge clk); #1;
    drive_vec();
    bus.start     = 1'b1;
    bus.out_ready = (stall == 0);
    e.y = ey; e.ovf = eovf; e.name = name;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 200) begin
      scramble_inputs();
      @(posedge clk); #1;
      cycles++;
      if (bus.y_valid) got = 1'b1;
      else bus.start = drop && (cycles == 5 || cycles == 12);
    end
    bus.start = 1'b0;
    check($sformatf("%s latency", name), 32'(cycles), 32'(N));
    if (!got) begin
      void'(sb_q.pop_back());
      return;
    end
    repeat (stall) begin
      @(posedge clk); #1;
      scramble_inputs();
    end
    bus.out_ready = 1'b1;
    bus.start     = drop;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check($sformatf("%s busy after handshake", name), 32'(bus.busy), 32'd0);
    check($sformatf("%s y_valid after handshake", name), 32'(bus.y_valid), 32'd0);
  endtask

  // Monitor: checks held outputs during stalls and pops the scoreboard on handshake.
  logic          held_valid = 1'b0;
  logic [YW-1:0] held_y;
  logic          held_ovf;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.y_valid) begin
        if (held_valid) begin
          check("hold y_data", 32'(bus.y_data), 32'(held_y));
          check("hold overflow", 32'(bus.overflow), 32'(held_ovf));
        end
        if (bus.out_ready) begin
          held_valid = 1'b0;
          if (sb_q.size() == 0) begin
            check("unexpected result", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("%s y_data", e.name), 32'(bus.y_data), 32'(e.y));
            check($sformatf("%s overflow", e.name), 32'(bus.overflow), 32'(e.ovf));
            $display("txn %s: y_data=%0h overflow=%0b", e.name, bus.y_data, bus.overflow);
          end
        end else begin
          held_valid = 1'b1;
          held_y     = bus.y_data;
          held_ovf   = bus.overflow;
        end
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  task automatic check_all_zero(input string name);
    check($sformatf("%s busy", name), 32'(bus.busy), 32'd0);
    check($sformatf("%s y_valid", name), 32'(bus.y_valid), 32'd0);
    check($sformatf("%s y_data", name), 32'(bus.y_data), 32'd0);
    check($sformatf("%s overflow", name), 32'(bus.overflow), 32'd0);
    check($sformatf("%s start_dropped", name), 32'(bus.start_dropped), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_flat    = '0;
    bus.w_flat    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("reset");

    set_all(16'd256, 8'd1);
    run_txn("x256_w1", 16'd20, 1'b0, 0, 1'b0);

    for (int i = 0; i < N; i++) begin
      xv[i] = XW'(i + 1);
      wv[i] = 8'd0;
    end
    // w=256 does not fit 8 bits; x scaled by 256 with w=1 gives the same 53760 sum.
    for (int i = 0; i < N; i++) begin
      xv[i] = XW'((i + 1) * 256);
      wv[i] = 8'd1;
    end
    run_txn("ramp", 16'd210, 1'b0, 0, 1'b0);

    set_all(16'hFFFF, 8'hFF);
    run_txn("full_scale", 16'hFFFF, 1'b1, 0, 1'b0);

    // Sum exactly 0xFFFFFF: shifted value is 0xFFFF, the largest that fits.
    set_all(16'd0, 8'd0);
    xv[0] = 16'hFFFF; wv[0] = 8'hFF;
    xv[1] = 16'hFFFF; wv[1] = 8'd1;
    xv[2] = 16'd255;  wv[2] = 8'd1;
    run_txn("edge_fit", 16'hFFFF, 1'b0, 0, 1'b0);
    xv[3] = 16'd1;    wv[3] = 8'd1;
    run_txn("edge_over", 16'hFFFF, 1'b1, 0, 1'b0);

    set_all(16'd1000, 8'd3);
    run_txn("stall7", 16'd234, 1'b0, 7, 1'b0);

    check("start_dropped before drops", 32'(bus.start_dropped), 32'd0);
    for (int i = 0; i < N; i++) begin
      xv[i] = XW'((i + 1) * 256);
      wv[i] = 8'd1;
    end
    run_txn("drops", 16'd210, 1'b0, 0, 1'b1);
    check("start_dropped after drops", 32'(bus.start_dropped), 32'd1);
    check("idle after drop handshake", 32'(bus.busy), 32'd0);

    set_all(16'd256, 8'd1);
    run_txn("after_drop", 16'd20, 1'b0, 0, 1'b0);

    // Abort mid-accumulation at idx 10.
    @(posedge clk); #1;
    set_all(16'hFFFF, 8'hFF);
    drive_vec();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("busy before abort", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all_zero("abort");

    set_all(16'd256, 8'd1);
    run_txn("post_reset", 16'd20, 1'b0, 0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
